pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Detects load-use hazards, branch mispredicts and instruction/data memory
// wait states, then drives the per-stage stall/flush controls. Also keeps
// saturating performance counters and a data-memory timeout flag.
// PARAMETERS
// REG_W      4    register-specifier width (16-entry register file)
// CNT_W      16   width of the performance counters
// MEM_TMO    64   DMEM_WAIT cycles before mem_timeout_err sets (>=2)
// PORTS
// clk              in   1      rising-edge clock
// rst_n            in   1      asynchronous reset, active low
// id_valid         in   1      ID stage holds a real instruction
// id_rs, id_rt     in   REG_W  ID source registers
// id_uses_rs/rt    in   1      source is actually read
// ex_valid         in   1      EX stage holds a real instruction
// ex_mem_read      in   1      EX instruction is a load
// ex_rd            in   REG_W  EX destination register
// br_mispredict    in   1      EX resolved branch wrong; PC redirect this cycle
// imem_ready       in   1      fetch data valid this cycle
// dmem_req         in   1      MEM stage is accessing data memory
// dmem_ready       in   1      data access completes this cycle
// pc_stall         out  1      hold PC
// if_id_stall      out  1      hold IF/ID register
// if_id_flush      out  1      load NOP into IF/ID
// id_ex_stall      out  1      hold ID/EX register
// id_ex_flush      out  1      load NOP into ID/EX
// ex_mem_stall     out  1      hold EX/MEM register
// mem_wb_bubble    out  1      write NOP into MEM/WB
// state            out  2      0=RUN 1=IMEM_WAIT 2=DMEM_WAIT
// stall_cnt        out  CNT_W  cycles with pc_stall=1, saturating
// flush_cnt        out  CNT_W  cycles with id_ex_flush=1, saturating
// mem_timeout_err  out  1      sticky; cleared only by reset
// BEHAVIOUR
// - While rst_n=0: all outputs 0, state=RUN, counters 0. This also applies mid-op.
// - Controls are combinational from inputs, with zero latency. state, counters
//   and the error flag are registered. Conditions are evaluated in strict
//   priority order; only the highest active one drives the controls:
//   P1 dmem: dmem_req & !dmem_ready -> pc_stall, if_id_stall, id_ex_stall,
//      ex_mem_stall, mem_wb_bubble = 1. No flush is asserted. br_mispredict
//      and load-use are ignored; upstream holds them until release.
//   P2 br_mispredict -> if_id_flush=1, id_ex_flush=1, pc_stall=0. This also
//      overrides an outstanding imem miss.
//   P3 load-use: ex_valid & ex_mem_read & id_valid & ((id_uses_rs & id_rs==ex_rd)
//      | (id_uses_rt & id_rt==ex_rd)) & ex_rd!=0 -> pc_stall, if_id_stall,
//      id_ex_flush = 1. Lasts exactly 1 cycle because the load advances.
//   P4 !imem_ready -> pc_stall=1, if_id_flush=1.
//   No condition active: all controls 0.
// - FSM next state (at posedge):
//   P1 active -> DMEM_WAIT; else P4 active and no P2 -> IMEM_WAIT; else RUN.
//   DMEM_WAIT->RUN in the cycle after dmem_ready=1.
// - Timeout: wait counter clears on entering DMEM_WAIT and increments each
//   DMEM_WAIT cycle. When it reaches MEM_TMO, mem_timeout_err<=1. The stall
//   continues regardless.
// - Counters increment by 1 per qualifying cycle and hold at 2^CNT_W-1.
//   A P2 cycle counts one flush.
// - Register 0 never produces a hazard. Invalid IDs/EXs never stall.
// TESTING
// 1 ex lw r3 (ex_mem_read=1, ex_rd=3), id add uses rs=3 -> 1 cycle
//   pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_cnt=1, flush_cnt=1.
// 2 Same as 1 but ex_rd=0, or id_uses_rs=0 -> no stall, counters unchanged.
// 3 dmem_req=1, dmem_ready low 3 cycles, with br_mispredict=1 throughout ->
//   freeze 3 cycles, no flush, state=2; next cycle flushes; state back to 0.
// 4 dmem_req=1, dmem_ready=0 for MEM_TMO+2 cycles -> mem_timeout_err=1 and
//   stays 1 after release; reset clears it.
// 5 imem_ready=0 for 2 cycles, br_mispredict in 2nd -> cycle1 pc_stall+if_id_flush,
//   state=1; cycle2 both flushes, pc_stall=0; next state=RUN.
// 6 CNT_W=4, stall 20 cycles -> stall_cnt=15. Assert rst_n low mid-DMEM_WAIT ->
//   all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Pipeline controls are combinational from the hazard inputs and are forced
// low while reset is held. The wait-state FSM, the performance counters and
// the data-memory timeout flag are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_mispredict,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IMEM_WAIT = 2'd1,
    ST_DMEM_WAIT = 2'd2
  } state_t;

  // The wait counter only needs to reach MEM_TMO; it saturates there.
  localparam int          TW     = $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] TMO_VAL = TW'(MEM_TMO);
  localparam logic [TW-1:0] TMO_M1  = TW'(MEM_TMO - 1);

  state_t             state_reg, state_next;
  logic [TW-1:0]      wait_cnt_reg;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
  logic               tmo_err_reg;

  logic p1_dmem, p2_branch, p3_load_use, p4_imem;
  logic rs_hit, rt_hit;

  // Hazard detection; register 0 is hard-wired and never forwards a hazard.
  always_comb begin
    rs_hit      = id_uses_rs && (id_rs == ex_rd);
    rt_hit      = id_uses_rt && (id_rt == ex_rd);
    p1_dmem     = dmem_req && !dmem_ready;
    p2_branch   = br_mispredict;
    p3_load_use = ex_valid && ex_mem_read && id_valid && (rs_hit || rt_hit)
                  && (ex_rd != '0);
    p4_imem     = !imem_ready;
  end

  // Priority-resolved pipeline controls; only the highest active hazard drives them.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst_n) begin
      if (p1_dmem) begin
        // Freeze everything upstream of MEM; held hazards are replayed on release.
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (p2_branch) begin
        // PC is being redirected, so a pending fetch miss is abandoned.
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (p3_load_use) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (p4_imem) begin
        pc_stall      = 1'b1;
        if_id_flush   = 1'b1;
      end
    end
  end

  // Next wait state.
  always_comb begin
    state_next = ST_RUN;
    if (p1_dmem)
      state_next = ST_DMEM_WAIT;
    else if (p4_imem && !p2_branch)
      state_next = ST_IMEM_WAIT;
  end

  // State register plus data-memory wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      tmo_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg != ST_DMEM_WAIT) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg != TMO_VAL) begin
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      end
      // Flag sets on the same edge the wait counter reaches MEM_TMO.
      if (state_reg == ST_DMEM_WAIT && wait_cnt_reg == TMO_M1)
        tmo_err_reg <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (id_ex_flush && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign state           = state_reg;
  assign stall_cnt       = stall_cnt_reg;
  assign flush_cnt       = flush_cnt_reg;
  assign mem_timeout_err = tmo_err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle control
// vectors followed by hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W   = 4;
  localparam int CNT_W   = 4;
  localparam int MEM_TMO = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_uses_rs, id_uses_rt;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             ex_valid, ex_mem_read, br_mispredict;
  logic             imem_ready, dmem_req, dmem_ready;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic             id_ex_flush, ex_mem_stall, mem_wb_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout_err;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_mispredict(br_mispredict), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  // Control bits in order: pc_stall if_id_stall if_id_flush id_ex_stall
  // id_ex_flush ex_mem_stall mem_wb_bubble
  logic [6:0] ctl;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, mem_wb_bubble};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_IM   = 7'b1010000;
  localparam logic [6:0] C_DM   = 7'b1101011;

  typedef struct {
    string      name;
    logic       idv;
    logic [3:0] rs, rt;
    logic       urs, urt, exv, exrd_ld;
    logic [3:0] rd;
    logic       br, imr, dreq, drdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic set_in(input vec_t v);
    id_valid = v.idv; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_valid = v.exv; ex_mem_read = v.exrd_ld; ex_rd = v.rd;
    br_mispredict = v.br; imem_ready = v.imr;
    dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  vec_t idle, lu;

  initial begin
    //           name       idv rs rt urs urt exv ld rd br imr dreq drdy exp
    vecs[0]  = '{"idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE};
    vecs[1]  = '{"lu_rs",      1, 3, 5, 1, 1, 1, 1, 3, 0, 1, 0, 0, C_LU};
    vecs[2]  = '{"lu_r0",      1, 0, 5, 1, 1, 1, 1, 0, 0, 1, 0, 0, C_NONE};
    vecs[3]  = '{"lu_nors",    1, 3, 5, 0, 1, 1, 1, 3, 0, 1, 0, 0, C_NONE};
    vecs[4]  = '{"lu_rt",      1, 2, 7, 0, 1, 1, 1, 7, 0, 1, 0, 0, C_LU};
    vecs[5]  = '{"lu_exinv",   1, 3, 5, 1, 1, 0, 1, 3, 0, 1, 0, 0, C_NONE};
    vecs[6]  = '{"lu_idinv",   0, 3, 5, 1, 1, 1, 1, 3, 0, 1, 0, 0, C_NONE};
    vecs[7]  = '{"lu_noload",  1, 3, 5, 1, 1, 1, 0, 3, 0, 1, 0, 0, C_NONE};
    vecs[8]  = '{"branch",     0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_BR};
    vecs[9]  = '{"imem_miss",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IM};
    vecs[10] = '{"br_over_im", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_BR};
    vecs[11] = '{"dmem_all",   1, 3, 5, 1, 1, 1, 1, 3, 1, 0, 1, 0, C_DM};
    vecs[12] = '{"dmem_done",  1, 3, 5, 1, 1, 1, 1, 3, 0, 1, 1, 1, C_LU};
    vecs[13] = '{"lu_over_im", 1, 3, 9, 1, 1, 1, 1, 9, 0, 0, 0, 0, C_LU};
    vecs[14] = '{"rdy_noreq",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_NONE};
    idle = vecs[0];
    lu   = vecs[1];

    // Reset with a load-use pattern on the inputs: everything must stay 0.
    rst_n = 1'b0;
    set_in(lu);
    step();
    @(negedge clk);
    chk("rst_ctl", int'(ctl), int'(C_NONE));
    chk("rst_state", int'(state), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    chk("rst_tmo", int'(mem_timeout_err), 0);
    step();
    rst_n = 1'b1;

    // Table of single-cycle control vectors.
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i]);
      @(negedge clk);
      chk({"vec_", vecs[i].name}, int'(ctl), int'(vecs[i].exp));
      step();
    end

    // One-cycle load-use stall, counted once in each counter.
    set_in(idle);
    do_reset();
    set_in(lu);
    @(negedge clk);
    chk("lu1_ctl", int'(ctl), int'(C_LU));
    step();
    set_in(idle);
    @(negedge clk);
    chk("lu1_after_ctl", int'(ctl), int'(C_NONE));
    chk("lu1_stall_cnt", int'(stall_cnt), 1);
    chk("lu1_flush_cnt", int'(flush_cnt), 1);

    // Non-hazards leave the counters alone.
    set_in(vecs[2]);
    step();
    set_in(vecs[3]);
    step();
    set_in(idle);
    @(negedge clk);
    chk("lu2_stall_cnt", int'(stall_cnt), 1);
    chk("lu2_flush_cnt", int'(flush_cnt), 1);

    // Data-memory freeze masks a held branch mispredict, which then flushes.
    do_reset();
    set_in(idle);
    br_mispredict = 1'b1;
    dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("dm_freeze_ctl%0d", c), int'(ctl), int'(C_DM));
      step();
      chk($sformatf("dm_freeze_state%0d", c), int'(state), 2);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("dm_release_ctl", int'(ctl), int'(C_BR));
    step();
    set_in(idle);
    @(negedge clk);
    chk("dm_release_state", int'(state), 0);
    chk("dm_release_flush_cnt", int'(flush_cnt), 1);
    chk("dm_release_stall_cnt", int'(stall_cnt), 3);

    // Fetch miss, then a mispredict overriding the miss.
    do_reset();
    set_in(idle);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("im_c1_ctl", int'(ctl), int'(C_IM));
    step();
    chk("im_c1_state", int'(state), 1);
    br_mispredict = 1'b1;
    @(negedge clk);
    chk("im_c2_ctl", int'(ctl), int'(C_BR));
    step();
    set_in(idle);
    @(negedge clk);
    chk("im_c2_state", int'(state), 0);

    // Timeout: not yet set well below MEM_TMO, set by MEM_TMO+2, sticky.
    do_reset();
    set_in(idle);
    dmem_req = 1'b1;
    for (int c = 0; c < MEM_TMO - 2; c++) step();
    @(negedge clk);
    chk("tmo_early", int'(mem_timeout_err), 0);
    for (int c = 0; c < 4; c++) step();
    @(negedge clk);
    chk("tmo_set", int'(mem_timeout_err), 1);
    chk("tmo_state", int'(state), 2);
    chk("tmo_still_frozen", int'(ctl), int'(C_DM));
    dmem_ready = 1'b1;
    step();
    set_in(idle);
    step();
    @(negedge clk);
    chk("tmo_sticky", int'(mem_timeout_err), 1);
    chk("tmo_after_state", int'(state), 0);
    do_reset();
    @(negedge clk);
    chk("tmo_cleared", int'(mem_timeout_err), 0);

    // Saturation of the 4-bit stall counter.
    set_in(idle);
    imem_ready = 1'b0;
    for (int c = 0; c < 20; c++) step();
    @(negedge clk);
    chk("sat_stall_cnt", int'(stall_cnt), 15);
    chk("sat_flush_cnt", int'(flush_cnt), 0);

    // Asynchronous reset in the middle of a data-memory wait.
    set_in(idle);
    dmem_req = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("arst_pre_state", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", int'(ctl), int'(C_NONE));
    chk("arst_state", int'(state), 0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
    chk("arst_flush_cnt", int'(flush_cnt), 0);
    chk("arst_tmo", int'(mem_timeout_err), 0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
